// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer
//   Exhaustive stimulus/checker stage for a 4-bit arithmetic unit.
//   Sweeps all 2048 {A,S1,S0,B,Cin} combinations, holds each one for SETTLE
//   cycles and then compares the unit's {Cout,D} against a golden result
//   computed one edge ahead and registered alongside the stimulus.
//
// Parameters
//   SETTLE  cycles a vector is held before its CHECK cycle (1..255)
//   ERR_W   mismatch counter width
//
// Ports
//   CLK, RSTn       clock (rising edge), async active-low reset
//   start           level run request, honoured in IDLE/DONE only
//   dut_result      {Cout,D[3:0]} from the unit under test
//   A, B, S1, S0, Cin  stimulus driven to the unit
//   goodresult      golden {Cout,D} for the driven vector
//   busy, done      sweep in progress / sweep complete (held)
//   mismatch        one-cycle pulse per failing vector
//   err_count       failing vectors this sweep, saturating
//   first_fail_vec  index of the first failing vector
module alu_vector_sequencer #(
  parameter int SETTLE = 8,
  parameter int ERR_W  = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic [4:0]       dut_result,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic             S1,
  output logic             S0,
  output logic             Cin,
  output logic [4:0]       goodresult,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [10:0]      first_fail_vec
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("SETTLE must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  // Field view of the vector index; packing order is the drive order.
  typedef struct packed {
    logic [3:0] a;
    logic [1:0] s;
    logic [3:0] b;
    logic       cin;
  } vec_t;

  localparam logic [7:0]  CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [10:0] VEC_LAST = 11'h7ff;

  state_t     state;
  vec_t       vec;
  logic [7:0] cnt;
  logic       err_full;

  // Golden {carry,sum} = A + Y + Cin, Y selected by {S1,S0}.
  function automatic logic [4:0] golden(input vec_t v);
    logic [3:0] y;
    case (v.s)
      2'b00:   y = v.b;
      2'b01:   y = ~v.b;
      2'b10:   y = 4'h0;
      default: y = 4'hf;
    endcase
    return {1'b0, v.a} + {1'b0, y} + {4'b0, v.cin};
  endfunction

  // Stimulus is the registered index itself, so it launches and holds
  // on exactly the same edges as goodresult.
  assign A        = vec.a;
  assign S1       = vec.s[1];
  assign S0       = vec.s[0];
  assign B        = vec.b;
  assign Cin      = vec.cin;
  assign err_full = &err_count;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      goodresult     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec            <= '0;
            goodresult     <= golden('0);
            cnt            <= CNT_LOAD;
            err_count      <= '0;
            first_fail_vec <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) state <= CHECK;
          else             cnt   <= cnt - 8'd1;
        end
        CHECK: begin
          if (dut_result != goodresult) begin
            mismatch <= 1'b1;
            if (!err_full)               err_count      <= err_count + ERR_W'(1);
            if (err_count == '0)         first_fail_vec <= vec;
          end
          if (vec == VEC_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec        <= vec + 11'd1;
            goodresult <= golden(vec + 11'd1);
            cnt        <= CNT_LOAD;
            state      <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_vector_sequencer.md
# alu_vector_sequencer

Self-checking stimulus stage placed directly upstream of the 4-bit arithmetic unit (A, B, S1, S0, Cin → D, Cout). It sweeps all 2048 input combinations and drives each one into the unit. After a programmable settle time it samples the unit's {Cout,D} and compares it against an internally computed golden result. It also counts mismatches and reports completion through a start/busy/done handshake.

## Interface
- SETTLE, 8: cycles each vector is held before its result is checked; legal range 1..255.
- ERR_W, 16: width of the mismatch counter.

- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled run request; honoured only in IDLE or DONE.
- dut_result  in  5  {Cout, D[3:0]} returned by the arithmetic unit.
- A  out  4  operand A to the unit.
- B  out  4  operand B to the unit.
- S1, S0  out  1 each  function select to the unit.
- Cin  out  1  carry-in to the unit.
- goodresult  out  5  golden {Cout,D} for the vector currently driven.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high once a sweep has completed; held until the next start or reset.
- mismatch  out  1  one-cycle pulse for each failing vector.
- err_count  out  ERR_W  number of failing vectors in the current sweep; saturates at all-ones.
- first_fail_vec  out  11  index of the first failing vector in the sweep.

## Operation
- Vector index vec[10:0] maps to the outputs as: A=vec[10:7], {S1,S0}=vec[6:5], B=vec[4:1], Cin=vec[0].
- Golden result is 5 bits, always A + Y + Cin with the carry kept in bit 4. Y depends on {S1,S0}:
  - 00: Y = B
  - 01: Y = ~B
  - 10: Y = 0000
  - 11: Y = 1111
- States are IDLE, WAIT, CHECK, DONE.
- IDLE → WAIT on start=1. On that edge:
  - vec ← 0, and the outputs and goodresult take vector 0.
  - cnt ← SETTLE−1.
  - err_count, first_fail_vec and done are cleared; busy ← 1.
- WAIT: if cnt==0, go to CHECK; otherwise decrement cnt.
- CHECK lasts one cycle. On the edge leaving CHECK:
  - If dut_result ≠ goodresult: mismatch ← 1 and err_count increments (saturating). If err_count was 0, first_fail_vec ← vec.
  - If vec==2047: go to DONE with busy ← 0 and done ← 1.
  - Otherwise: vec ← vec+1, outputs and goodresult update, cnt ← SETTLE−1, go to WAIT.
- DONE: outputs hold the last vector. start=1 restarts exactly as from IDLE.
- start is ignored while in WAIT or CHECK.

## Timing
- Reset values: every output is 0; state is IDLE; vec = 0; cnt = 0.
- RSTn low at any time, mid-sweep included, forces reset values immediately, without waiting for a clock. No result is reported for the aborted sweep.
- Vector period is SETTLE+1 cycles: SETTLE cycles in WAIT plus 1 cycle in CHECK.
- A vector's outputs are stable from the edge that launches it until the edge leaving its CHECK.
- dut_result is compared during the CHECK cycle. The unit's combinational delay must be shorter than SETTLE clock periods.
- mismatch is high for exactly the one cycle after the failing CHECK.
- done and busy change on the edge leaving the final CHECK. A mismatch on vector 2047 pulses in the same cycle that done rises.
- Total time from the start edge to done rising is 2048·(SETTLE+1) cycles.
- goodresult is registered and changes on the same edge as A, B, S1, S0 and Cin.

## Test plan
- Reset: drive RSTn=0 mid-sweep at vec=100 → all outputs 0 asynchronously. Release, then start → sweep restarts at vec 0 with err_count=0.
- Clean sweep: dut_result fed by a correct behavioural ALU, SETTLE=8, start pulsed → done rises exactly 18432 cycles after the start edge, err_count=0, mismatch never asserted.
- Golden spot checks:
  - A=5, S=01, B=3, Cin=1 → goodresult=10010.
  - A=15, S=11, Cin=1 → goodresult=11111.
  - A=0, S=01, B=0, Cin=0 → goodresult=01111.
  - A=9, S=10, Cin=0 → goodresult=01001.
- Fault injection: ALU model with D[0] stuck-at-0 → err_count=1024, first_fail_vec=1, 1024 mismatch pulses in total.
- Handshake:
  - start held high throughout the sweep → no restart while busy.
  - start in DONE → done clears, err_count clears, and vector 0 is driven on the next edge.
- Saturation: ERR_W=4 with dut_result tied to 0 → err_count stops at 15, first_fail_vec=1.
